load_align_unit: RTL and testbench
==================================

# load_align_unit

Read-side alignment engine for the data memory port. It accepts RISC-V load requests with arbitrary byte addresses and issues one or two word reads to the synchronous-read data RAM (1-cycle read latency). It merges and shifts the returned words, then sign- or zero-extends the result and returns one registered response. It is the load-direction counterpart of the store-side byte-lane shifting in the data segment, and it adds support for loads that cross a word boundary.

## Interface
Parameters:
- none; widths are fixed (32-bit data and address, 5-bit destination tag)

Ports:
- clk  in  1  rising-edge clock; single clock domain
- rst  in  1  synchronous, active-high reset
- req_valid  in  1  load request present
- req_ready  out  1  unit can accept a request this cycle
- req_addr  in  32  byte address, any alignment
- req_type  in  3  funct3: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; others are invalid
- req_rd  in  5  destination register tag, returned unchanged
- mem_a  out  32  byte address to the data RAM, bits [1:0] always 00
- mem_rd  in  32  RAM read data, valid one cycle after mem_a is sampled
- resp_valid  out  1  one-cycle pulse: the response is valid
- resp_data  out  32  extended load result
- resp_rd  out  5  tag of the completed request
- resp_err  out  1  qualified by resp_valid; the request used an invalid req_type

## Operation
- States: IDLE, RD0 (first word returning), RD1 (second word returning).
- req_ready = !rst && state==IDLE. A request is accepted when req_valid && req_ready.
- On accept, the unit registers addr_q, type_q and rd_q, then moves IDLE→RD0.
- mem_a:
  - In IDLE: {req_addr[31:2],2'b00}, combinational, so the RAM samples the first word address in the accept cycle.
  - In RD0 when crossing: {addr_q[31:2]+1,2'b00}. This wraps 0xFFFFFFFC→0x00000000.
  - Otherwise: {addr_q[31:2],2'b00}.
- Crossing condition:
  - LH/LHU with addr[1:0]==11
  - LW with addr[1:0]!=00
  - LB/LBU never cross
  - invalid types never cross
- RD0:
  - Not crossing: form the result from {32'b0, mem_rd}, register the response, go to IDLE.
  - Crossing: latch mem_rd into lo_q, go to RD1.
- RD1: form the result from {mem_rd, lo_q}, register the response, go to IDLE.
- Extraction: shift the 64-bit value right by 8*addr_q[1:0] and take bits [7:0], [15:0] or [31:0].
  - LB and LH sign-extend from bit 7 / bit 15.
  - LBU and LHU zero-extend.
- Invalid type: one access only; resp_err=1 and resp_data=0.
- req_addr, req_type and req_rd are ignored outside the accept cycle.

## Timing
- Reset values: state IDLE, resp_valid 0, resp_data 0, resp_rd 0, resp_err 0, lo_q 0, req_ready 0 while rst=1. mem_a follows req_addr, which is harmless.
- Non-crossing: accept at cycle T; resp_valid=1 during T+2.
- Crossing: accept at T; second word address driven at T+1; resp_valid=1 during T+3.
- resp_valid lasts exactly one cycle. resp_data, resp_rd and resp_err hold their values until the next response.
- Back-to-back: the unit is in IDLE again in the response cycle and may accept a new request there. Peak throughput is one non-crossing load per 2 cycles.
- rst asserted in RD0 or RD1: the request is abandoned, no response is produced, and the unit is in IDLE next cycle.
- rst together with req_valid: the request is not accepted.
- There is no back-pressure on the response. The consumer must take it in the pulse cycle.

## Test plan
- Memory word0=0x8899AABB. LB @0x1 → resp_data 0xFFFFFFAA at T+2. LBU @0x1 → 0x000000AA.
- LH @0x2 with word0=0x8899AABB → 0xFFFF8899. LHU @0x0 → 0x0000AABB. resp_rd echoes req_rd=5'd7.
- Word0=0x44332211, word1=0x88776655. LW @0x1 → 0x55443322 at T+3, mem_a=0x4 at T+1. LH @0x3 → 0x00005544.
- Wrap: LW @0xFFFFFFFE with word@0xFFFFFFFC=0xDDCCBBAA and word@0x0=0x00001122 → mem_a 0x0 in the second access, resp_data 0x1122DDCC.
- Invalid req_type=011 @0x4 → resp_valid with resp_err=1 and resp_data=0 at T+2. The next valid LW is accepted in the same cycle and completes correctly.
- Assert rst in RD1 of a crossing LW → no resp_valid. req_ready=1 one cycle after rst deasserts. A following LB @0x0 returns normally.

Source files
------------

// File: rtl/load_align_unit.sv
// Load-side alignment engine: issues one or two word reads for an arbitrarily aligned
// RISC-V load, merges the returned words, extends the result and returns a registered response.
module load_align_unit (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [31:0] req_addr,
   input  logic [2:0]  req_type,
   input  logic [4:0]  req_rd,
   output logic [31:0] mem_a,
   input  logic [31:0] mem_rd,
   output logic        resp_valid,
   output logic [31:0] resp_data,
   output logic [4:0]  resp_rd,
   output logic        resp_err
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RD0  = 2'd1,
      ST_RD1  = 2'd2
   } state_t;

   state_t      state_r;
   state_t      next_state_s;
   logic [31:0] addr_r;
   logic [2:0]  type_r;
   logic [4:0]  rd_r;
   logic [31:0] lo_r;
   logic        accept_s;
   logic        cross_s;
   logic        type_ok_s;

   function automatic logic type_valid(input logic [2:0] typ);
      case (typ)
         3'b000, 3'b001, 3'b010, 3'b100, 3'b101: type_valid = 1'b1;
         default:                                type_valid = 1'b0;
      endcase
   endfunction

   // A load crosses when its last byte lies in the next word; invalid types never do.
   function automatic logic crosses(input logic [1:0] ofs, input logic [2:0] typ);
      case (typ)
         3'b001, 3'b101: crosses = (ofs == 2'b11);
         3'b010:         crosses = (ofs != 2'b00);
         default:        crosses = 1'b0;
      endcase
   endfunction

   function automatic logic [31:0] extract(input logic [63:0] raw, input logic [1:0] ofs,
                                           input logic [2:0] typ);
      logic [31:0] sh;
      sh = 32'(raw >> {ofs, 3'b000});
      case (typ)
         3'b000:  extract = {{24{sh[7]}}, sh[7:0]};
         3'b001:  extract = {{16{sh[15]}}, sh[15:0]};
         3'b010:  extract = sh;
         3'b100:  extract = {24'h000000, sh[7:0]};
         3'b101:  extract = {16'h0000, sh[15:0]};
         default: extract = 32'h0000_0000;
      endcase
   endfunction

   assign accept_s  = req_valid && req_ready;
   assign cross_s   = crosses(addr_r[1:0], type_r);
   assign type_ok_s = type_valid(type_r);

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= next_state_s;
      end
   end

   // Next-state logic.
   always_comb begin
      next_state_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (accept_s) begin
               next_state_s = ST_RD0;
            end else begin
               next_state_s = ST_IDLE;
            end
         end
         ST_RD0: begin
            if (cross_s) begin
               next_state_s = ST_RD1;
            end else begin
               next_state_s = ST_IDLE;
            end
         end
         ST_RD1:  next_state_s = ST_IDLE;
         default: next_state_s = ST_IDLE;
      endcase
   end

   // RAM address and handshake; the first word address is driven in the accept cycle.
   always_comb begin
      req_ready = 1'b0;
      mem_a     = {addr_r[31:2], 2'b00};
      case (state_r)
         ST_IDLE: begin
            req_ready = !rst;
            mem_a     = {req_addr[31:2], 2'b00};
         end
         ST_RD0: begin
            if (cross_s) begin
               mem_a = {addr_r[31:2] + 30'd1, 2'b00};
            end else begin
               mem_a = {addr_r[31:2], 2'b00};
            end
         end
         ST_RD1:  mem_a = {addr_r[31:2], 2'b00};
         default: mem_a = {addr_r[31:2], 2'b00};
      endcase
   end

   // Request capture, low-word latch and registered response.
   always_ff @(posedge clk) begin
      if (rst) begin
         addr_r     <= 32'h0000_0000;
         type_r     <= 3'b000;
         rd_r       <= 5'd0;
         lo_r       <= 32'h0000_0000;
         resp_valid <= 1'b0;
         resp_data  <= 32'h0000_0000;
         resp_rd    <= 5'd0;
         resp_err   <= 1'b0;
      end else begin
         resp_valid <= 1'b0;
         case (state_r)
            ST_IDLE: begin
               if (accept_s) begin
                  addr_r <= req_addr;
                  type_r <= req_type;
                  rd_r   <= req_rd;
               end
            end
            ST_RD0: begin
               if (cross_s) begin
                  lo_r <= mem_rd;
               end else begin
                  resp_valid <= 1'b1;
                  resp_data  <= extract({32'h0000_0000, mem_rd}, addr_r[1:0], type_r);
                  resp_rd    <= rd_r;
                  resp_err   <= !type_ok_s;
               end
            end
            ST_RD1: begin
               resp_valid <= 1'b1;
               resp_data  <= extract({mem_rd, lo_r}, addr_r[1:0], type_r);
               resp_rd    <= rd_r;
               resp_err   <= 1'b0;
            end
            default: begin
               resp_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_load_align_unit.sv
// Directed and randomized bench for load_align_unit against a byte-level load model
// and a synchronous-read RAM model.
module tb_load_align_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid;
   logic        req_ready;
   logic [31:0] req_addr;
   logic [2:0]  req_type;
   logic [4:0]  req_rd;
   logic [31:0] mem_a;
   logic [31:0] mem_rd;
   logic        resp_valid;
   logic [31:0] resp_data;
   logic [4:0]  resp_rd;
   logic        resp_err;

   int vectors = 0;
   int miscompares = 0;

   logic [31:0] mem [logic [29:0]];

   load_align_unit dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_addr(req_addr), .req_type(req_type), .req_rd(req_rd),
      .mem_a(mem_a), .mem_rd(mem_rd),
      .resp_valid(resp_valid), .resp_data(resp_data),
      .resp_rd(resp_rd), .resp_err(resp_err)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] word_at(input logic [29:0] wa);
      if (mem.exists(wa)) return mem[wa];
      else return {wa, 2'b00} ^ 32'hA5C3_5A3C;
   endfunction

   // Synchronous-read RAM, one cycle latency.
   always @(posedge clk) mem_rd <= word_at(mem_a[31:2]);

   function automatic logic [7:0] byte_at(input logic [31:0] a);
      logic [31:0] w;
      w = word_at(a[31:2]);
      return w[8*a[1:0] +: 8];
   endfunction

   // Reference: gather bytes little-endian one at a time, then extend.
   function automatic void model(input logic [31:0] addr, input logic [2:0] typ,
                                 output logic [31:0] data, output logic err, output int lat);
      int size;
      logic [31:0] v;
      case (typ)
         3'b000, 3'b100: size = 1;
         3'b001, 3'b101: size = 2;
         3'b010:         size = 4;
         default:        size = 0;
      endcase
      v = 32'd0;
      for (int i = 0; i < size; i++) v = v | (32'(byte_at(addr + 32'(i))) << (8 * i));
      if (size != 0 && typ[2] == 1'b0 && v[8*size-1]) begin
         for (int i = 8 * size; i < 32; i++) v[i] = 1'b1;
      end
      data = v;
      err  = (size == 0);
      lat  = (size != 0 && (int'(addr[1:0]) + size > 4)) ? 3 : 2;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Called at a negedge with the unit idle; returns at the negedge of the response cycle.
   task automatic run_load(input logic [31:0] addr, input logic [2:0] typ, input logic [4:0] rd);
      logic [31:0] ed;
      logic        ee;
      int          el;
      int          lat;
      model(addr, typ, ed, ee, el);
      chk("req_ready", 32'(req_ready), 32'd1);
      req_valid = 1'b1; req_addr = addr; req_type = typ; req_rd = rd;
      #1;
      chk("mem_a_first", mem_a, {addr[31:2], 2'b00});
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0; req_addr = $urandom; req_type = 3'($urandom); req_rd = 5'($urandom);
      if (el == 3) chk("mem_a_second", mem_a, {addr[31:2] + 30'd1, 2'b00});
      lat = 1;
      while (!resp_valid && lat < 8) begin
         @(negedge clk);
         lat++;
      end
      chk("resp_valid", 32'(resp_valid), 32'd1);
      chk("latency", 32'(lat), 32'(el));
      chk("resp_data", resp_data, ed);
      chk("resp_rd", 32'(resp_rd), 32'(rd));
      chk("resp_err", 32'(resp_err), 32'(ee));
   endtask

   initial begin
      int seen;
      logic [2:0] types [7];
      types = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101, 3'b011, 3'b111};
      rst = 1'b1; req_valid = 1'b0; req_addr = 32'd0; req_type = 3'd0; req_rd = 5'd0;
      mem[30'd0] = 32'h8899AABB;
      repeat (3) @(negedge clk);
      req_valid = 1'b1;
      #1;
      chk("reset_ready", 32'(req_ready), 32'd0);
      chk("reset_valid", 32'(resp_valid), 32'd0);
      chk("reset_data", resp_data, 32'd0);
      chk("reset_rd", 32'(resp_rd), 32'd0);
      chk("reset_err", 32'(resp_err), 32'd0);
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      rst = 1'b0;
      #1;
      chk("no_accept_in_reset", 32'(resp_valid), 32'd0);

      run_load(32'h1, 3'b000, 5'd3);
      chk("lb_plan", resp_data, 32'hFFFFFFAA);
      run_load(32'h1, 3'b100, 5'd4);
      chk("lbu_plan", resp_data, 32'h000000AA);
      run_load(32'h2, 3'b001, 5'd7);
      chk("lh_plan", resp_data, 32'hFFFF8899);
      run_load(32'h0, 3'b101, 5'd7);
      chk("lhu_plan", resp_data, 32'h0000AABB);

      mem[30'd0] = 32'h44332211;
      mem[30'd1] = 32'h88776655;
      run_load(32'h1, 3'b010, 5'd9);
      chk("lw_cross_plan", resp_data, 32'h55443322);
      run_load(32'h3, 3'b101, 5'd10);
      chk("lhu_cross_plan", resp_data, 32'h00005544);

      mem[30'h3FFFFFFF] = 32'hDDCCBBAA;
      mem[30'd0] = 32'h00001122;
      run_load(32'hFFFFFFFE, 3'b010, 5'd11);
      chk("lw_wrap_plan", resp_data, 32'h1122DDCC);

      run_load(32'h4, 3'b011, 5'd12);
      chk("invalid_err", 32'(resp_err), 32'd1);
      run_load(32'h4, 3'b010, 5'd13);

      // Abandon a crossing LW with reset in RD1.
      @(negedge clk);
      req_valid = 1'b1; req_addr = 32'h1; req_type = 3'b010; req_rd = 5'd14;
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      seen = 0;
      for (int i = 0; i < 4; i++) begin
         #1;
         if (resp_valid) seen++;
         if (i == 0) chk("ready_after_rst", 32'(req_ready), 32'd1);
         @(negedge clk);
      end
      chk("abandoned_no_resp", 32'(seen), 32'd0);
      run_load(32'h0, 3'b000, 5'd15);

      // Random loads over a small pool of words plus the top of memory.
      for (int w = 0; w < 16; w++) mem[30'(w)] = $urandom;
      mem[30'h3FFFFFFF] = $urandom;
      mem[30'h3FFFFFFE] = $urandom;
      for (int n = 0; n < 150; n++) begin
         logic [31:0] a;
         a = ($urandom_range(0, 9) == 0) ? (32'hFFFFFFF8 + 32'($urandom_range(0, 7)))
                                         : 32'($urandom_range(0, 63));
         if ($urandom_range(0, 3) == 0) @(negedge clk);
         run_load(a, types[$urandom_range(0, 6)], 5'($urandom));
      end
      @(negedge clk);
      chk("pulse_one_cycle", 32'(resp_valid), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout vectors=%0d", vectors);
      $fatal(1, "timeout");
   end

endmodule
